ins_mem_loader: RTL and testbench

Program loader that writes a byte stream into the instruction memory of the five-stage pipeline CPU. It accepts instruction bytes LSB-first on a valid/ready interface and writes them to consecutive byte addresses from `BASE_ADDR`, giving little-endian 32-bit instructions. After the stream ends it back-fills the rest of memory with the halt instruction. It holds the CPU in reset/stall (`cpu_hold`) for the whole session. It is the write-side counterpart of the instruction fetch memory.

---
 rtl/loader_pkg.sv | 17 +
 rtl/ins_mem_loader.sv | 119 +++++++++++
 tb/tb_ins_mem_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM states and the
// halt instruction used to back-fill memory after a program is loaded.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE,
        ST_ERR
    } state_t;

    // beq x0,x0,0 spins in place, so a runaway PC parks harmlessly
    localparam logic [31:0] HALT_INSTR = 32'h00000063;
    localparam logic [7:0]  HALT_BYTE0 = HALT_INSTR[7:0];

endpackage

// File: rtl/ins_mem_loader.sv
// Streams instruction bytes into instruction memory little-endian from BASE_ADDR,
// back-fills the remainder with halt instructions, and holds the CPU meanwhile.
module ins_mem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] word_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              fill_wr;
    logic              start_ok;
    logic              last_written;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FILL lingers one cycle so that done rises only after the final write is visible
    assign last_written = mem_we && (mem_addr == LAST);

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (in_last) begin
                        if (ptr[1:0] != 2'd3) begin
                            next_state = ST_ERR;
                        end else if (ptr == LAST) begin
                            next_state = ST_DONE;
                        end else begin
                            next_state = ST_FILL;
                        end
                    end else if (ptr == LAST) begin
                        next_state = ST_ERR;
                    end
                end
            end
            ST_FILL: begin
                if (last_written) begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_LOAD);
        busy     = (state == ST_LOAD) || (state == ST_FILL);
        cpu_hold = (state == ST_LOAD) || (state == ST_FILL);
        done     = (state == ST_DONE);
        error    = (state == ST_ERR);
        start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
        accept   = in_valid && (state == ST_LOAD);
        fill_wr  = (state == ST_FILL) && !last_written;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= BASE;
            word_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= 8'h00;
        end else begin
            mem_we <= accept || fill_wr;
            if (start_ok) begin
                ptr        <= BASE;
                word_count <= '0;
            end else if (accept) begin
                ptr       <= ptr + 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= in_byte;
                if (ptr[1:0] == 2'd3) begin
                    word_count <= word_count + 1'b1;
                end
            end else if (fill_wr) begin
                ptr       <= ptr + 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= (ptr[1:0] == 2'd0) ? HALT_BYTE0 : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: directed and random load sessions
// compared against a byte-stream model of the expected memory writes.
module tb_ins_mem_loader;
    import loader_pkg::*;

    localparam int DEPTH     = 128;
    localparam int ADDR_W    = 7;
    localparam int BASE_ADDR = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-2:0] word_count;

    ins_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   wrAddr[$];
    int   wrData[$];
    int   wrCyc[$];
    int   doneRise[$];
    int   errRise[$];
    logic prevDone = 1'b0;
    logic prevErr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write pulse and status rising edge is logged with the cycle it appeared in
    always @(negedge clk) begin
        if (mem_we) begin
            wrAddr.push_back(int'(mem_addr));
            wrData.push_back(int'(mem_wdata));
            wrCyc.push_back(cyc);
        end
        if (done && !prevDone) doneRise.push_back(cyc);
        if (error && !prevErr) errRise.push_back(cyc);
        prevDone <= done;
        prevErr  <= error;
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] stim[0:DEPTH+1];
    int         expAddr[$];
    int         expData[$];
    bit         expDone;
    bit         expErr;
    bit         expFill;
    int         expWc;
    int         nLoad;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected write list derived directly from the byte stream and session rules
    task automatic buildModel(input int n, input bit withLast);
        expAddr.delete();
        expData.delete();
        nLoad = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < nLoad; i++) begin
            expAddr.push_back(BASE_ADDR + i);
            expData.push_back(int'(stim[i]));
        end
        expDone = withLast && (n <= DEPTH) && (n % 4 == 0);
        expErr  = !expDone;
        expFill = expDone && (n < DEPTH);
        expWc   = nLoad / 4;
        if (expFill) begin
            for (int a = n; a < DEPTH; a++) begin
                expAddr.push_back(a);
                expData.push_back(int'((HALT_INSTR >> (8 * (a % 4))) & 32'hFF));
            end
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input bit withLast, input int gapMode);
        bit gap;
        for (int i = 0; i < n; i++) begin
            gap = 1'b0;
            if (gapMode == 1) gap = (i > 0);
            if (gapMode == 2) gap = ($urandom_range(0, 1) == 1);
            if (gap) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_byte  = stim[i];
            in_last  = withLast && (i == n - 1);
            if (i >= DEPTH) begin
                checkOutput("in_ready_after_overflow", 32'(in_ready), 32'd0);
                break;
            end else if (in_ready !== 1'b1) begin
                checkOutput($sformatf("in_ready_load_byte%0d", i), 32'(in_ready), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitEnd(input string tag);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done || error) break;
        end
        checkOutput({tag, "_ended"}, 32'(done | error), 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic verifySession(input string tag, input int wrBase, input int doneBase,
                                 input int errBase, input bit loadGapFree);
        int nSeen;
        int nCmp;
        int lastCyc;
        nSeen = wrAddr.size() - wrBase;
        nCmp  = (nSeen < expAddr.size()) ? nSeen : expAddr.size();
        checkOutput({tag, "_write_count"}, 32'(nSeen), 32'(expAddr.size()));
        for (int i = 0; i < nCmp; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wrAddr[wrBase + i]), 32'(expAddr[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(wrData[wrBase + i]), 32'(expData[i]));
        end
        for (int i = 1; i < nSeen; i++) begin
            if (loadGapFree || i >= nLoad) begin
                checkOutput($sformatf("%s_spacing%0d", tag, i),
                            32'(wrCyc[wrBase + i] - wrCyc[wrBase + i - 1]), 32'd1);
            end
        end
        lastCyc = (nSeen > 0) ? wrCyc[wrAddr.size() - 1] : 0;
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
        checkOutput({tag, "_error"}, 32'(error), 32'(expErr));
        checkOutput({tag, "_word_count"}, 32'(word_count), 32'(expWc));
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        if (expDone) begin
            checkOutput({tag, "_done_rises"}, 32'(doneRise.size() - doneBase), 32'd1);
            if (doneRise.size() > doneBase) begin
                checkOutput({tag, "_done_timing"}, 32'(doneRise[doneRise.size() - 1] - lastCyc),
                            expFill ? 32'd1 : 32'd0);
            end
        end else begin
            checkOutput({tag, "_error_rises"}, 32'(errRise.size() - errBase), 32'd1);
            if (errRise.size() > errBase) begin
                checkOutput({tag, "_error_timing"}, 32'(errRise[errRise.size() - 1] - lastCyc), 32'd0);
            end
        end
    endtask

    task automatic runSession(input string tag, input int n, input bit withLast, input int gapMode);
        int wrBase;
        int doneBase;
        int errBase;
        buildModel(n, withLast);
        wrBase   = wrAddr.size();
        doneBase = doneRise.size();
        errBase  = errRise.size();
        pulseStart();
        checkOutput({tag, "_start_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_start_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_start_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "_start_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_start_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_start_wc"}, 32'(word_count), 32'd0);
        applyStimulus(n, withLast, gapMode);
        waitEnd(tag);
        verifySession(tag, wrBase, doneBase, errBase, gapMode == 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(BASE_ADDR));
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        int preCount;
        int wrBase;
        int n;
        logic [7:0] basic[0:7];
        basic = '{8'h93, 8'h00, 8'h80, 8'h00, 8'h13, 8'h61, 8'h20, 8'h00};

        #2;
        checkAllZero("reset");
        #10 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) stim[i] = basic[i];
        runSession("basic", 8, 1'b1, 0);
        runSession("backpressure", 8, 1'b1, 1);

        for (int i = 0; i < DEPTH + 2; i++) stim[i] = 8'($urandom);
        runSession("misaligned", 6, 1'b1, 0);
        for (int i = 0; i < DEPTH + 2; i++) stim[i] = 8'($urandom);
        runSession("overflow", DEPTH + 1, 1'b0, 0);
        for (int i = 0; i < DEPTH + 2; i++) stim[i] = 8'($urandom);
        runSession("exact", DEPTH, 1'b1, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH + 2; i++) stim[i] = 8'($urandom);
            n = (r % 2 == 0) ? 4 * $urandom_range(1, DEPTH / 4) : $urandom_range(1, DEPTH);
            runSession($sformatf("rand%0d", r), n, 1'b1, 2);
        end

        // Start pulse mid-load must be ignored, then reset aborts the session
        for (int i = 0; i < DEPTH + 2; i++) stim[i] = 8'($urandom);
        wrBase = wrAddr.size();
        pulseStart();
        in_valid = 1'b1;
        in_byte  = stim[0];
        @(posedge clk); #1;
        in_byte = stim[1];
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        in_byte = stim[2];
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("midload_busy", 32'(busy), 32'd1);
        checkOutput("midload_wc", 32'(word_count), 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        checkAllZero("rst_mid");
        preCount = wrAddr.size();
        checkOutput("rst_pre_writes", 32'(preCount - wrBase), 32'd3);
        for (int i = 0; i < 3 && wrBase + i < preCount; i++) begin
            checkOutput($sformatf("rst_pre_addr%0d", i), 32'(wrAddr[wrBase + i]), 32'(BASE_ADDR + i));
            checkOutput($sformatf("rst_pre_data%0d", i), 32'(wrData[wrBase + i]), 32'(stim[i]));
        end
        repeat (3) @(negedge clk);
        checkOutput("rst_no_writes", 32'(wrAddr.size() - preCount), 32'd0);
        checkOutput("rst_hold_mem_we", 32'(mem_we), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        runSession("after_reset", 4, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
